// File: rtl/rl_fifo_pkg.sv
// rtl/rl_fifo_pkg.sv - shared types and width helpers for the RAM-backed FIFO controller
package rl_fifo_pkg;

  // Occupancy of the two-entry output stage
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Level counts RAM words plus one in-flight read plus two staged words
  localparam int LVL_XTRA_BITS = 2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  function automatic int ptr_w(input int abits);
    return abits + 1;
  endfunction

  function automatic int lvl_w(input int abits);
    return abits + LVL_XTRA_BITS;
  endfunction

endpackage

// File: rtl/rl_skid_buf2.sv
// rtl/rl_skid_buf2.sv - two-entry in-order output stage fed by RAM read data
module rl_skid_buf2
  import rl_fifo_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [DBITS-1:0] data_i,
  input  logic             pop_i,
  output logic [DBITS-1:0] data_o,
  output logic             valid_o,
  output occ_e             occ_o
);

  occ_e             occ_q;
  logic [DBITS-1:0] head_q;
  logic [DBITS-1:0] tail_q;

  // Occupancy FSM: head always holds the oldest word, tail the younger one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush_i) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_i) begin
            head_q <= data_i;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push_i, pop_i})
            2'b10: begin
              tail_q <= data_i;
              occ_q  <= OCC_TWO;
            end
            2'b01: occ_q <= OCC_EMPTY;
            2'b11: head_q <= data_i;
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (pop_i) begin
            head_q <= tail_q;
            if (push_i) tail_q <= data_i;
            else        occ_q  <= OCC_ONE;
          end
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

  assign data_o  = head_q;
  assign valid_o = (occ_q != OCC_EMPTY);
  assign occ_o   = occ_q;

  // The read-issue rule upstream must never deliver a word into a full stage
  assert property (@(posedge clk_i) disable iff (rst_i) !(occ_q == OCC_TWO && push_i));

endmodule

// File: rtl/rl_ram_1r1w_fifo_ctrl.sv
// rtl/rl_ram_1r1w_fifo_ctrl.sv - FIFO controller using an external 1R1W RAM as storage
module rl_ram_1r1w_fifo_ctrl
  import rl_fifo_pkg::*;
#(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [DBITS-1:0]       s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [DBITS-1:0]       m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [ABITS+1:0]       level_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  output logic                   ram_re_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam int PW = ptr_w(ABITS);
  localparam int LW = lvl_w(ABITS);
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {ABITS{1'b0}}};

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_d;
  logic [PW-1:0] rptr_d;
  logic [PW-1:0] ram_lvl;
  logic          s_ready_q;
  logic          rd_pend_q;
  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    stage_need;
  occ_e          occ;
  logic [1:0]    occ_bits;

  // A flush cycle refuses pushes so nothing lands in RAM that is about to be forgotten
  assign s_ready_o = s_ready_q & ~flush_i;
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i & ~flush_i;

  assign ram_lvl   = wptr_q - rptr_q;

  // Words the output stage will have to hold if another read is issued now
  assign occ_bits   = occ;
  assign stage_need = {1'b0, occ_bits} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue      = (ram_lvl != '0) & (stage_need < 3'd2) & ~flush_i;

  assign wptr_d = wptr_q + {{(PW-1){1'b0}}, push};
  assign rptr_d = rptr_q + {{(PW-1){1'b0}}, issue};

  // Pointer, pending-read and ready bookkeeping; ready looks ahead at next-cycle RAM level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_pend_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else if (flush_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_pend_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_pend_q <= issue;
      s_ready_q <= ((wptr_d - rptr_d) != FULL_LVL);
    end
  end

  // RAM read data arrives one cycle after issue and is captured straight into the stage
  rl_skid_buf2 #(
    .DBITS (DBITS)
  ) u_stage (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (rd_pend_q),
    .data_i  (ram_dout_i),
    .pop_i   (pop),
    .data_o  (m_data_o),
    .valid_o (m_valid_o),
    .occ_o   (occ)
  );

  assign ram_waddr_o = wptr_q[ABITS-1:0];
  assign ram_din_o   = s_data_i;
  assign ram_we_o    = push;
  assign ram_be_o    = '1;
  assign ram_raddr_o = rptr_q[ABITS-1:0];
  assign ram_re_o    = issue;

  assign level_o = LW'(ram_lvl) + LW'(rd_pend_q) + LW'(occ_bits);

  // A read only targets written words and a write never targets a full RAM, so addresses differ
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(ram_we_o && ram_re_o && (ram_waddr_o == ram_raddr_o)));

endmodule
